// File: rtl/prog_mem_controller_pkg.sv
// Shared definitions for the program memory controller: FSM state encodings
// and the round-robin pointer advance helper.
package prog_mem_controller_pkg;

  typedef enum logic [1:0] {
    MC_IDLE         = 2'b00,
    MC_READ_WAITING = 2'b01,
    MC_RELAYING     = 2'b10
  } mc_state_e;

  // Advance with an explicit wrap so non-power-of-two consumer counts work.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/prog_mem_controller_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_grant_o
);

  int idx;

  // Scan farthest-first so the requester closest to the pointer lands last.
  always_comb begin
    gnt_idx_o   = '0;
    any_grant_o = 1'b0;
    idx         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (req_i[idx]) begin
        gnt_idx_o   = IW'(idx);
        any_grant_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_mem_controller.sv
// Arbitrates several instruction fetchers onto one program memory port,
// serving one read at a time and relaying data back until the fetcher lets go.
module prog_mem_controller
  import prog_mem_controller_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_WIDTH    = 6,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0] consumer_read_addr,
  output logic [NUM_CONSUMERS-1:0]            consumer_read_ack,
  output logic [NUM_CONSUMERS*DATA_WIDTH-1:0] consumer_read_data,
  output logic                                mem_read_valid,
  output logic [ADDR_WIDTH-1:0]               mem_read_addr,
  input  logic                                mem_read_ready,
  input  logic [DATA_WIDTH-1:0]               mem_read_data
);

  localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  mc_state_e                         state_q, state_d;
  logic [IW-1:0]                     gnt_q, gnt_d, rr_q, rr_d, arb_idx;
  logic                              arb_any;
  logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
  logic                              mvld_q, mvld_d;
  logic [NUM_CONSUMERS-1:0]          ack_q, ack_d;
  logic [NUM_CONSUMERS*DATA_WIDTH-1:0] data_q, data_d;

  rr_arbiter #(.N(NUM_CONSUMERS), .IW(IW)) u_arb (
    .req_i       (consumer_read_valid),
    .ptr_i       (rr_q),
    .gnt_idx_o   (arb_idx),
    .any_grant_o (arb_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    mvld_d  = mvld_q;
    ack_d   = ack_q;
    data_d  = data_q;
    case (state_q)
      MC_IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_idx;
          addr_d  = consumer_read_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          mvld_d  = 1'b1;
          state_d = MC_READ_WAITING;
        end
      end
      // The read always completes, even if the requester has withdrawn.
      MC_READ_WAITING: begin
        if (mem_read_ready) begin
          mvld_d = 1'b0;
          data_d[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH] = mem_read_data;
          ack_d[gnt_q] = 1'b1;
          state_d = MC_RELAYING;
        end
      end
      MC_RELAYING: begin
        if (!consumer_read_valid[gnt_q]) begin
          ack_d   = '0;
          rr_d    = IW'(rr_next(int'(gnt_q), NUM_CONSUMERS));
          state_d = MC_IDLE;
        end
      end
      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MC_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      mvld_q  <= 1'b0;
      ack_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      mvld_q  <= mvld_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end

  assign consumer_read_ack  = ack_q;
  assign consumer_read_data = data_q;
  assign mem_read_valid     = mvld_q;
  assign mem_read_addr      = addr_q;

endmodule

// File: tb/tb_prog_mem_controller.sv
// Bench for prog_mem_controller: fetcher and memory models with a grant/data
// scoreboard, plus a 3-consumer instance for pointer wrap.
module tb_prog_mem_controller;
  localparam int N = 4, AW = 6, DW = 32, N3 = 3;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    cv, cack;
  logic [N*AW-1:0] caddr;
  logic [N*DW-1:0] cdata;
  logic            mvld, mrdy;
  logic [AW-1:0]   maddr;
  logic [DW-1:0]   mdata;

  logic [N3-1:0]    v3 = '0, ack3;
  logic [N3*AW-1:0] a3;
  logic [N3*DW-1:0] d3;
  logic             mv3, r3 = 1'b0;
  logic [AW-1:0]    ma3;
  logic [DW-1:0]    md3 = '0;

  always #5 clk = ~clk;

  prog_mem_controller #(.NUM_CONSUMERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .consumer_read_valid(cv), .consumer_read_addr(caddr),
    .consumer_read_ack(cack), .consumer_read_data(cdata),
    .mem_read_valid(mvld), .mem_read_addr(maddr),
    .mem_read_ready(mrdy), .mem_read_data(mdata));

  prog_mem_controller #(.NUM_CONSUMERS(N3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut3 (
    .clk(clk), .rst(rst),
    .consumer_read_valid(v3), .consumer_read_addr(a3),
    .consumer_read_ack(ack3), .consumer_read_data(d3),
    .mem_read_valid(mv3), .mem_read_addr(ma3),
    .mem_read_ready(r3), .mem_read_data(md3));

  typedef struct {int idx; logic [DW-1:0] data; int len;} exp_t;
  typedef struct {logic [N-1:0] req; int cnt; int lat; logic [AW-1:0] base; int n; logic [7:0][3:0] ord;} vec_t;

  exp_t sb[$];
  int   got3[$];
  int   checks = 0, failures = 0;
  logic [DW-1:0] mem_img [64];
  logic [N-1:0]  auto_en, drop_pend, rereq_pend, prev_ack;
  int   rem[N], cnt_tot[N], ack_len[N], exp_len[N];
  logic [AW-1:0] base, hold_addr;
  bit   hold_vld, mem_auto, en3;
  int   mem_lat, wait_cnt;
  logic [N3-1:0] prev_ack3;
  vec_t vt[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] req_addr(input int i, input int r);
    return base + AW'(i * 4 + r);
  endfunction

  // One clock: sample after the edge, score acks, then drive memory and fetchers.
  task automatic tick();
    @(posedge clk); #1;
    check("ack_onehot", 128'($countones(cack) <= 1), 128'(1));
    for (int i = 0; i < N; i++) begin
      if (cack[i] && !prev_ack[i]) begin
        ack_len[i] = 0;
        if (sb.size() == 0) check("sb_underflow", 128'(sb.size()), 128'(1));
        else begin
          exp_t e;
          e = sb.pop_front();
          check("grant_idx", 128'(i), 128'(e.idx));
          check("ack_data", 128'(cdata[i*DW +: DW]), 128'(e.data));
          exp_len[i] = e.len;
        end
      end
      if (cack[i]) ack_len[i]++;
      if (!cack[i] && prev_ack[i] && exp_len[i] != 0) begin
        check("ack_len", 128'(ack_len[i]), 128'(exp_len[i]));
        exp_len[i] = 0;
      end
    end
    prev_ack = cack;
    if (mvld) begin
      if (hold_vld) check("addr_stable", 128'(maddr), 128'(hold_addr));
      hold_addr = maddr;
      hold_vld  = 1'b1;
    end else hold_vld = 1'b0;
    if (mem_auto) begin
      if (mrdy) begin mrdy = 1'b0; wait_cnt = 0; end
      else if (mvld) begin
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin mrdy = 1'b1; mdata = mem_img[maddr]; end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (auto_en[i]) begin
        if (drop_pend[i]) begin
          cv[i] = 1'b0; drop_pend[i] = 1'b0; rem[i]--;
          if (rem[i] > 0) rereq_pend[i] = 1'b1;
        end else if (rereq_pend[i]) begin
          cv[i] = 1'b1; caddr[i*AW +: AW] = req_addr(i, cnt_tot[i] - rem[i]); rereq_pend[i] = 1'b0;
        end else if (cv[i] && cack[i]) drop_pend[i] = 1'b1;
      end
    end
    if (en3) begin
      check("n3_onehot", 128'($countones(ack3) <= 1), 128'(1));
      if (r3) r3 = 1'b0;
      else if (mv3) begin r3 = 1'b1; md3 = mem_img[ma3]; end
      for (int i = 0; i < N3; i++) begin
        if (ack3[i] && !prev_ack3[i]) got3.push_back(i);
        if (ack3[i] && v3[i]) v3[i] = 1'b0;
        else if (!v3[i]) v3[i] = 1'b1;
      end
      prev_ack3 = ack3;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cv = '0; auto_en = '0; drop_pend = '0; rereq_pend = '0;
    mrdy = 1'b0; wait_cnt = 0; sb.delete();
    for (int i = 0; i < N; i++) exp_len[i] = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int t;
    t = 0;
    while ((sb.size() != 0 || cv != '0 || cack != '0) && t < 300) begin tick(); t++; end
    check(name, 128'(t < 300), 128'(1));
    check("idle_mvld", 128'(mvld), 128'(0));
  endtask

  initial begin
    rst = 1'b1; cv = '0; caddr = '0; mrdy = 1'b0; mdata = '0;
    prev_ack = '0; prev_ack3 = '0; hold_vld = 1'b0; mem_auto = 1'b0; en3 = 1'b0;
    base = '0; mem_lat = 1; wait_cnt = 0; hold_addr = '0;
    for (int i = 0; i < N3; i++) a3[i*AW +: AW] = AW'(i + 1);
    for (int a = 0; a < 64; a++) mem_img[a] = {8'hA5, 8'(a), 8'(~a), 8'(a * 3)};
    mem_img[6'h15] = 32'hDEADBEEF;

    vt[0] = '{req: 4'b0100, cnt: 1, lat: 3, base: 6'h0D, n: 1, ord: 32'h2};
    vt[1] = '{req: 4'b1111, cnt: 1, lat: 1, base: 6'h00, n: 4, ord: 32'h3210};
    vt[2] = '{req: 4'b1111, cnt: 2, lat: 1, base: 6'h10, n: 8, ord: 32'h32103210};
    vt[3] = '{req: 4'b1010, cnt: 2, lat: 2, base: 6'h01, n: 4, ord: 32'h3131};
    vt[4] = '{req: 4'b0001, cnt: 3, lat: 2, base: 6'h30, n: 3, ord: 32'h000};

    do_reset();
    check("rst_ack", 128'(cack), 128'(0));
    check("rst_mvld", 128'(mvld), 128'(0));
    check("rst_maddr", 128'(maddr), 128'(0));
    check("rst_data", 128'(cdata), 128'(0));

    for (int v = 0; v < 5; v++) begin
      int seen[N];
      do_reset();
      base = vt[v].base; mem_lat = vt[v].lat; mem_auto = 1'b1;
      for (int i = 0; i < N; i++) seen[i] = 0;
      for (int j = 0; j < vt[v].n; j++) begin
        int idx;
        idx = int'(vt[v].ord[j]);
        sb.push_back('{idx, mem_img[req_addr(idx, seen[idx])], 2});
        seen[idx]++;
      end
      for (int i = 0; i < N; i++) begin
        auto_en[i] = vt[v].req[i]; cnt_tot[i] = vt[v].cnt;
        rem[i] = vt[v].req[i] ? vt[v].cnt : 0;
        if (vt[v].req[i]) begin cv[i] = 1'b1; caddr[i*AW +: AW] = req_addr(i, 0); end
      end
      wait_quiet("vec_timeout");
      for (int i = 0; i < N; i++)
        if (vt[v].req[i])
          check("data_hold", 128'(cdata[i*DW +: DW]), 128'(mem_img[req_addr(i, vt[v].cnt - 1)]));
    end

    // Consumer 1 withdraws while its read is outstanding; consumer 2 is next.
    do_reset();
    base = 6'h20; mem_lat = 4; mem_auto = 1'b1;
    auto_en = 4'b0100; rem[2] = 1; cnt_tot[2] = 1;
    caddr[1*AW +: AW] = req_addr(1, 0); caddr[2*AW +: AW] = req_addr(2, 0);
    sb.push_back('{1, mem_img[req_addr(1, 0)], 1});
    sb.push_back('{2, mem_img[req_addr(2, 0)], 2});
    cv = 4'b0110;
    tick(); tick();
    cv[1] = 1'b0;
    wait_quiet("withdraw_timeout");

    // Reset while waiting on memory, with a ready pulse landing around it.
    mem_auto = 1'b0; auto_en = '0;
    cv[0] = 1'b1; caddr[0 +: AW] = 6'h05;
    tick();
    check("rw_mvld", 128'(mvld), 128'(1));
    check("rw_maddr", 128'(maddr), 128'(6'h05));
    tick();
    rst = 1'b1; mrdy = 1'b1; mdata = 32'h12345678;
    tick();
    rst = 1'b0;
    check("mid_rst_mvld", 128'(mvld), 128'(0));
    check("mid_rst_maddr", 128'(maddr), 128'(0));
    check("mid_rst_ack", 128'(cack), 128'(0));
    check("mid_rst_data", 128'(cdata), 128'(0));
    tick();
    mrdy = 1'b0;
    check("idle_ready_ack", 128'(cack), 128'(0));
    check("regrant_mvld", 128'(mvld), 128'(1));
    tick();
    check("idle_ready_ack2", 128'(cack), 128'(0));
    cv = '0;
    do_reset();

    // Three consumers requesting continuously: pointer must wrap 2 -> 0.
    en3 = 1'b1;
    for (int t = 0; t < 60; t++) tick();
    en3 = 1'b0;
    check("n3_grants", 128'(got3.size() >= 5), 128'(1));
    for (int k = 0; k < 5 && k < got3.size(); k++)
      check("n3_order", 128'(got3[k]), 128'(k % 3));
    check("n3_data0", 128'(d3[0 +: DW]), 128'(mem_img[1]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prog_mem_controller.md
PROG_MEM_CONTROLLER -- requirements
Module: prog_mem_controller

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 4: number of fetchers sharing program memory.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6: program memory address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: instruction width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port consumer_read_valid  input  NUM_CONSUMERS  per-fetcher read request, held until ack.
REQ-007 SHALL have port consumer_read_addr  input  NUM_CONSUMERS*ADDR_WIDTH  flattened request addresses; consumer i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have port consumer_read_ack  output  NUM_CONSUMERS  per-fetcher ack; data valid while high.
REQ-009 SHALL have port consumer_read_data  output  NUM_CONSUMERS*DATA_WIDTH  flattened returned instructions.
REQ-010 SHALL have port mem_read_valid  output  1  request to program memory.
REQ-011 SHALL have port mem_read_addr  output  ADDR_WIDTH  address to program memory.
REQ-012 SHALL have port mem_read_ready  input  1  memory completion strobe, data valid same cycle.
REQ-013 SHALL have port mem_read_data  input  DATA_WIDTH  memory read data.

Function
REQ-014 SHALL implement FSM states IDLE, READ_WAITING, RELAYING.
REQ-015 IDLE: if any consumer_read_valid is high, SHALL grant one consumer round-robin from rr_ptr, latch index and address, set mem_read_valid=1, mem_read_addr=addr, and go to READ_WAITING; otherwise stay.
REQ-016 READ_WAITING: on mem_read_ready=1, SHALL set mem_read_valid=0, write mem_read_data to the granted consumer's data slice, set that consumer's ack=1, and go to RELAYING.
REQ-017 READ_WAITING: mem_read_valid and mem_read_addr SHALL stay stable until mem_read_ready; memory latency is unbounded.
REQ-018 RELAYING: when the granted consumer's valid is 0, SHALL clear its ack, set rr_ptr=(granted+1) mod NUM_CONSUMERS, and return to IDLE; otherwise hold ack high.
REQ-019 At most one ack bit SHALL be high at any time; each consumer's data slice SHALL hold its last value until overwritten.
REQ-020 Minimum latency SHALL be: valid sampled at edge E0; mem_read_valid high after E0; ack high after the edge where ready is sampled (earliest E1).
REQ-021 Consumers not granted SHALL keep requests pending, with no loss. Service SHALL be strictly one transaction at a time.
REQ-022 A consumer dropping valid while in READ_WAITING SHALL NOT abort the memory read; the ack is then high for exactly one cycle.
REQ-023 mem_read_ready SHALL be ignored outside READ_WAITING.
REQ-024 Fairness: with all consumers requesting continuously, grants SHALL rotate 0,1,2,3,0...
REQ-025 rr_ptr wrap SHALL use modulo NUM_CONSUMERS and SHALL be correct for non-power-of-two counts.

Reset
REQ-026 On rst: state=IDLE, mem_read_valid=0, mem_read_addr=0, all acks=0, all data slices=0, rr_ptr=0, grant index=0.
REQ-027 Reset mid-transaction SHALL abandon it with no ack issued; outputs SHALL reach reset values after that edge.
REQ-028 Reset SHALL take priority over all other inputs.

Structure
REQ-029 State encodings SHALL live in common_defs.v: MC_IDLE=2'b00, MC_READ_WAITING=2'b01, MC_RELAYING=2'b10.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs: request vector, pointer; outputs: grant index, any_grant).

Verification
REQ-031 Single request: consumer 2 requests addr 0x15, memory ready 3 cycles later with 0xDEADBEEF -> mem_read_addr=0x15; ack[2]=1 with data slice 2=0xDEADBEEF; ack drops one cycle after valid drops.
REQ-032 All four consumers request simultaneously, fixed 1-cycle memory -> grants served in order 0,1,2,3; never more than one ack high.
REQ-033 Fetcher-style handshake (consumer drops valid the edge after seeing ack) -> ack high exactly 2 cycles; controller back in IDLE.
REQ-034 rst asserted in READ_WAITING, then mem_read_ready pulses -> no ack; mem_read_valid=0; state IDLE.
REQ-035 NUM_CONSUMERS=3, continuous requests -> grant sequence 0,1,2,0,1 (pointer wrap).
REQ-036 Consumer 1 withdraws valid during READ_WAITING -> read completes; ack[1] high exactly 1 cycle; next grant goes to consumer 2 if it is requesting.
